// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the write-back request type for the write-back arbiter.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 1 << REG_AW;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order holding FIFO for load results, exposing per-entry valid bits and destinations.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  wb_req_t                       i_data,
  input  logic                          i_pop,
  output wb_req_t                       o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [AW:0]                   o_count,
  output logic [DEPTH-1:0]              o_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  o_addr
);
  wb_req_t           r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [DEPTH-1:0]  r_valid;
  logic              w_push, w_pop;
  logic [DEPTH-1:0]  w_set, w_clr;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign w_set   = DEPTH'(w_push) << r_wptr;
  assign w_clr   = DEPTH'(w_pop) << r_rptr;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_valid <= (r_valid & ~w_clr) | w_set;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_addr[i] = r_mem[i].addr;
  end
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_valid = r_valid;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the never-stalled ALU stream with buffered LSU load results onto one register-file write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_alu_valid,
  input  logic [REG_AW-1:0]         i_alu_rd_addr,
  input  logic [XLEN-1:0]           i_alu_rd_data,
  input  logic                      i_lsu_valid,
  output logic                      o_lsu_ready,
  input  logic [REG_AW-1:0]         i_lsu_rd_addr,
  input  logic [XLEN-1:0]           i_lsu_rd_data,
  output logic                      o_rd_wren,
  output logic [REG_AW-1:0]         o_rd_addr,
  output logic [XLEN-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0]    o_fifo_count,
  output logic [NREGS-1:0]          o_pending_mask
);
  wb_req_t                      w_alu, w_lsu, w_head, w_sel;
  logic                         w_full, w_empty, w_acc, w_push, w_pop, w_issue;
  logic [DEPTH-1:0]             w_valid;
  logic [DEPTH-1:0][REG_AW-1:0] w_addr;
  logic [NREGS-1:0]             w_mask;
  logic                         r_wren;
  logic [REG_AW-1:0]            r_addr;
  logic [XLEN-1:0]              r_data;
  assign w_alu = '{addr: i_alu_rd_addr, data: i_alu_rd_data};
  assign w_lsu = '{addr: i_lsu_rd_addr, data: i_lsu_rd_data};
  // Ready is gated by reset so nothing is accepted while the FIFO is being cleared.
  assign o_lsu_ready = i_rst_n & ~w_full;
  assign w_acc   = i_lsu_valid & o_lsu_ready;
  assign w_pop   = ~i_alu_valid & ~w_empty;
  assign w_push  = w_acc & (i_alu_valid | ~w_empty);
  assign w_issue = i_alu_valid | ~w_empty | w_acc;
  assign w_sel   = i_alu_valid ? w_alu : ~w_empty ? w_head : w_lsu;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_lsu),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count),
    .o_valid (w_valid),
    .o_addr  (w_addr)
  );
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) if (w_valid[i]) w_mask[w_addr[i]] = 1'b1;
    w_mask[0] = 1'b0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_issue & (w_sel.addr != '0);
      if (w_issue) begin
        r_addr <= w_sel.addr;
        r_data <= w_sel.data;
      end
    end
  end
  assign o_rd_wren      = r_wren;
  assign o_rd_addr      = r_addr;
  assign o_rd_data      = r_data;
  assign o_pending_mask = w_mask;
endmodule
